// File: rtl/data_axi_bridge.sv
// Data-side SRAM-to-AXI bridge: one single-beat AXI read or write per load/store.
// Latency >= 3 stall cycles per access; holds the pipeline via stallreq until all AXI handshakes complete.
module data_axi_bridge #(
    parameter logic [3:0] AXI_ID = 4'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [1:0]  data_sram_size,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        stallreq,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_AR = 3'd1,
        S_RD_R  = 3'd2,
        S_WR    = 3'd3,
        S_WR_B  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [3:0]  r_wen;
    logic [1:0]  r_size;
    logic        r_aw_done;
    logic        r_w_done;

    logic        w_accept;
    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_wr_both;
    logic        w_busy;

    assign w_accept  = (r_state == S_IDLE) & data_sram_en & ~flush;
    assign w_aw_hs   = awvalid & awready;
    assign w_w_hs    = wvalid & wready;
    // Either channel may finish first; both must be done before waiting for B.
    assign w_wr_both = (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs);
    assign w_busy    = (r_state == S_RD_AR) | (r_state == S_RD_R) |
                       (r_state == S_WR)    | (r_state == S_WR_B);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        arvalid = 1'b0;
        rready  = 1'b0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = (data_sram_wen == 4'd0) ? S_RD_AR : S_WR;
                end
            end
            S_RD_AR: begin
                arvalid = 1'b1;
                if (arready) begin
                    w_next = S_RD_R;
                end
            end
            S_RD_R: begin
                rready = 1'b1;
                if (rvalid) begin
                    w_next = S_DONE;
                end
            end
            S_WR: begin
                awvalid = ~r_aw_done;
                wvalid  = ~r_w_done;
                if (w_wr_both) begin
                    w_next = S_WR_B;
                end
            end
            S_WR_B: begin
                bready = 1'b1;
                if (bvalid) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr    <= 32'd0;
            r_wdata   <= 32'd0;
            r_wen     <= 4'd0;
            r_size    <= 2'd0;
            r_rdata   <= 32'd0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr  <= data_sram_addr;
                r_wdata <= data_sram_wdata;
                r_wen   <= data_sram_wen;
                r_size  <= data_sram_size;
            end
            if ((r_state == S_RD_R) && rvalid) begin
                r_rdata <= rdata;
            end
            if (r_state == S_WR) begin
                if (w_wr_both) begin
                    r_aw_done <= 1'b0;
                    r_w_done  <= 1'b0;
                end else begin
                    if (w_aw_hs) begin
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_w_done <= 1'b1;
                    end
                end
            end
        end
    end

    // Gated by reset so the pipeline is released the instant reset asserts.
    assign stallreq        = rst & (w_accept | w_busy);
    assign data_sram_rdata = r_rdata;

    assign arid   = AXI_ID;
    assign awid   = AXI_ID;
    assign wid    = AXI_ID;
    assign araddr = r_addr;
    assign awaddr = r_addr;
    assign arsize = {1'b0, r_size};
    assign awsize = {1'b0, r_size};
    assign wdata  = r_wdata;
    assign wstrb  = r_wen;
    assign wlast  = 1'b1;

endmodule
